// File: rtl/acc_mem_responder.sv
// acc_mem_responder
//   Memory-side responder for the edge-detection accelerator bus. Owns the
//   image store: the input image at words 0..IMG_WORDS-1 and the result image
//   from OUT_BASE onward. A host sequence is: host_go, stream the input image
//   in, pulse acc_start, serve accelerator reads/writes until acc_finish, then
//   stream the result image back out.
//
//   Handshakes (load and dump streams): a word moves on a rising clk edge
//   exactly when valid and ready are both 1 in the cycle before that edge.
//   A source holds valid and its data stable until the word moves; ready
//   may change freely and never depends on valid in the same cycle.
//
// Ports:
//   clk, reset      clock; asynchronous active-high reset
//   acc_addr/en/we  accelerator word address, request, write select
//   acc_dataW       accelerator write data
//   acc_dataR       registered read data, holds until the next read
//   acc_start       one-cycle start pulse; acc_finish completion level
//   host_go         start a load/run/dump sequence (honoured in IDLE/DONE)
//   load_valid/ready/data          host -> store input image stream
//   dump_valid/ready/data/last     store -> host result image stream
//   busy, done      status; err sticky protocol error
//   run_cycles      saturating count of cycles spent in RUN
module acc_mem_responder #(
    parameter int ADDR_W    = 16,
    parameter int IMG_WORDS = 25344,
    parameter int OUT_BASE  = 25344,
    parameter int MEM_WORDS = 50688
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] acc_addr,
    input  logic              acc_en,
    input  logic              acc_we,
    input  logic [31:0]       acc_dataW,
    output logic [31:0]       acc_dataR,
    output logic              acc_start,
    input  logic              acc_finish,
    input  logic              host_go,
    input  logic              load_valid,
    input  logic [31:0]       load_data,
    output logic              load_ready,
    output logic              dump_valid,
    output logic [31:0]       dump_data,
    output logic              dump_last,
    input  logic              dump_ready,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [31:0]       run_cycles
);

    localparam int MA_W  = $clog2(MEM_WORDS);
    localparam int CNT_W = $clog2(IMG_WORDS + 1);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(IMG_WORDS - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_START, S_RUN, S_DUMP, S_DONE
    } state_t;

    state_t state, state_nxt;

    logic [31:0]      mem [MEM_WORDS];
    logic [31:0]      ram_q;
    logic             mem_we, mem_re;
    logic [MA_W-1:0]  mem_addr;
    logic [31:0]      mem_wdata;

    logic [CNT_W-1:0] ld_cnt, fetch_cnt;
    logic             ram_v, ram_last, rd_ok;
    logic             go_accept, run_acc, acc_in_range, load_fire;
    logic             out_free, dump_fetch;

    // ---------------- FSM ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        acc_start  = 1'b0;
        load_ready = 1'b0;
        busy       = 1'b1;
        done       = 1'b0;
        case (state)
            S_IDLE: begin
                busy = 1'b0;
                if (host_go) state_nxt = S_LOAD;
            end
            S_LOAD: begin
                load_ready = 1'b1;
                if (load_valid && ld_cnt == LAST_IDX) state_nxt = S_START;
            end
            S_START: begin
                acc_start = 1'b1;
                state_nxt = S_RUN;
            end
            S_RUN: begin
                if (acc_finish) state_nxt = S_DUMP;
            end
            S_DUMP: begin
                if (dump_valid && dump_ready && dump_last) state_nxt = S_DONE;
            end
            S_DONE: begin
                busy = 1'b0;
                done = 1'b1;
                if (host_go) state_nxt = S_LOAD;
            end
            default: begin
                busy      = 1'b0;
                state_nxt = S_IDLE;
            end
        endcase
    end

    // ---------------- single storage port, steered by state ----------------
    assign go_accept    = host_go && (state == S_IDLE || state == S_DONE);
    assign run_acc      = (state == S_RUN) && acc_en;
    assign acc_in_range = 32'(acc_addr) < 32'(MEM_WORDS);
    assign load_fire    = load_valid && load_ready;

    // Output register is free when empty or being drained this cycle; a new
    // fetch may issue whenever the RAM stage will be empty after this edge.
    assign out_free   = !dump_valid || dump_ready;
    assign dump_fetch = (state == S_DUMP) && (32'(fetch_cnt) < 32'(IMG_WORDS))
                        && (!ram_v || out_free);

    always_comb begin
        mem_we    = load_fire || (run_acc && acc_we && acc_in_range);
        mem_re    = (run_acc && !acc_we && acc_in_range) || dump_fetch;
        mem_wdata = (state == S_LOAD) ? load_data : acc_dataW;
        mem_addr  = MA_W'(acc_addr);
        if (state == S_LOAD) mem_addr = MA_W'(ld_cnt);
        if (state == S_DUMP) mem_addr = MA_W'(OUT_BASE) + MA_W'(fetch_cnt);
    end

    always_ff @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
        if (mem_re) ram_q <= mem[mem_addr];
    end

    // ram_q is shared with the dump path, so the accelerator view is masked:
    // rd_ok marks ram_q as holding the last in-range accelerator read.
    assign acc_dataR = rd_ok ? ram_q : 32'h0;

    // ---------------- load counter, status ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ld_cnt     <= '0;
            err        <= 1'b0;
            run_cycles <= '0;
            rd_ok      <= 1'b0;
        end else begin
            if (go_accept)      ld_cnt <= '0;
            else if (load_fire) ld_cnt <= ld_cnt + CNT_W'(1);

            if (go_accept) begin
                err        <= 1'b0;
                run_cycles <= '0;
            end else begin
                if (acc_en && (state != S_RUN || !acc_in_range)) err <= 1'b1;
                if (state == S_RUN && run_cycles != '1) run_cycles <= run_cycles + 32'd1;
            end

            if (run_acc && !acc_we) rd_ok <= acc_in_range;
            else if (dump_fetch)    rd_ok <= 1'b0;
        end
    end

    // ---------------- dump pipeline: RAM stage + output register ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_cnt  <= '0;
            ram_v      <= 1'b0;
            ram_last   <= 1'b0;
            dump_valid <= 1'b0;
            dump_data  <= '0;
            dump_last  <= 1'b0;
        end else if (state != S_DUMP) begin
            fetch_cnt  <= '0;
            ram_v      <= 1'b0;
            ram_last   <= 1'b0;
            dump_valid <= 1'b0;
            dump_last  <= 1'b0;
        end else begin
            if (ram_v && out_free) begin
                dump_valid <= 1'b1;
                dump_data  <= ram_q;
                dump_last  <= ram_last;
            end else if (dump_ready) begin
                dump_valid <= 1'b0;
                dump_last  <= 1'b0;
            end

            if (dump_fetch) begin
                ram_v     <= 1'b1;
                ram_last  <= (fetch_cnt == LAST_IDX);
                fetch_cnt <= fetch_cnt + CNT_W'(1);
            end else if (out_free) begin
                ram_v <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_acc_mem_responder.sv
module tb_acc_mem_responder;

    localparam int ADDR_W    = 16;
    localparam int IMG_WORDS = 25344;
    localparam int OUT_BASE  = 25344;
    localparam int MEM_WORDS = 50688;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic [ADDR_W-1:0] acc_addr = '0;
    logic              acc_en = 1'b0, acc_we = 1'b0, acc_finish = 1'b0;
    logic [31:0]       acc_dataW = '0, acc_dataR;
    logic              acc_start;
    logic              host_go = 1'b0, load_valid = 1'b0, load_ready;
    logic [31:0]       load_data = '0;
    logic              dump_valid, dump_last, dump_ready = 1'b0;
    logic [31:0]       dump_data;
    logic              busy, done, err;
    logic [31:0]       run_cycles;

    acc_mem_responder #(
        .ADDR_W(ADDR_W), .IMG_WORDS(IMG_WORDS), .OUT_BASE(OUT_BASE), .MEM_WORDS(MEM_WORDS)
    ) dut (
        .clk(clk), .reset(reset),
        .acc_addr(acc_addr), .acc_en(acc_en), .acc_we(acc_we),
        .acc_dataW(acc_dataW), .acc_dataR(acc_dataR),
        .acc_start(acc_start), .acc_finish(acc_finish),
        .host_go(host_go),
        .load_valid(load_valid), .load_data(load_data), .load_ready(load_ready),
        .dump_valid(dump_valid), .dump_data(dump_data), .dump_last(dump_last),
        .dump_ready(dump_ready),
        .busy(busy), .done(done), .err(err), .run_cycles(run_cycles)
    );

    // ---------------- scoreboard ----------------
    int checks = 0;
    int failures = 0;
    int run_n = 0;
    logic [31:0] res_exp [int];   // known result-region words, keyed by dump index

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic pulse_go();
        @(negedge clk); host_go = 1'b1;
        @(negedge clk); host_go = 1'b0;
    endtask

    task automatic run_cyc(input logic en, input logic we, input logic [15:0] addr,
                           input logic [31:0] wd, input logic fin);
        @(negedge clk);
        acc_en = en; acc_we = we; acc_addr = addr; acc_dataW = wd; acc_finish = fin;
        run_n++;
    endtask

    // Streams words 0,1,2,... with data = word index; during the first
    // gap_cycles cycles valid is offered only every 3rd cycle.
    task automatic do_load(input int gap_cycles, output int accepted);
        int cnt;
        bit ended;
        cnt = 0;
        ended = 1'b0;
        for (int cyc = 0; cyc < IMG_WORDS + gap_cycles + 20; cyc++) begin
            @(negedge clk);
            if (cnt > 0 && !load_ready) begin
                ended = 1'b1;
                break;
            end
            load_valid = (cyc < gap_cycles) ? (cyc % 3 == 0) : 1'b1;
            load_data  = 32'(cnt);
            if (load_valid && load_ready) cnt++;
        end
        load_valid = 1'b0;
        if (!ended) check("load_timeout", 32'd0, 32'd1);
        accepted = cnt;
    endtask

    // Full result dump; first negedge is the cycle right after acc_finish.
    task automatic do_dump_full();
        int k;
        logic [7:0] stall_pat;
        stall_pat = 8'b1001_1001;   // ready 1,0,0,1,1,0,0,1
        k = 0;
        for (int cyc = 0; cyc < IMG_WORDS + 50 && k < IMG_WORDS; cyc++) begin
            @(negedge clk);
            acc_finish = 1'b0;
            if (cyc == 0) check("run_cycles_100", run_cycles, 32'd100);
            dump_ready = (cyc >= 2 && cyc < 10) ? stall_pat[cyc-2] : 1'b1;
            if (cyc >= 2) check("dump_valid_stream", {31'b0, dump_valid}, 32'd1);
            if (dump_valid) begin
                if (res_exp.exists(k))
                    check($sformatf("dump_word_%0d", k), dump_data, res_exp[k]);
                if (dump_last || k == IMG_WORDS - 1)
                    check($sformatf("dump_last_%0d", k), {31'b0, dump_last},
                          {31'b0, (k == IMG_WORDS - 1)});
                if (dump_ready) k++;
            end
        end
        @(negedge clk);
        check("dump_word_count", 32'(k), 32'(IMG_WORDS));
        check("dump_valid_after_last", {31'b0, dump_valid}, 32'd0);
        check("done_after_dump", {31'b0, done}, 32'd1);
        check("busy_after_dump", {31'b0, busy}, 32'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int acc_cnt;

        res_exp[0] = 32'hDEADBEEF;
        for (int i = 1; i < 8; i++) res_exp[i] = 32'hA000_0000 | 32'(i);
        res_exp[IMG_WORDS-2] = 32'hB000_0001;
        res_exp[IMG_WORDS-1] = 32'hB000_0002;

        repeat (3) @(negedge clk);
        check("rst_acc_start",  {31'b0, acc_start},  32'd0);
        check("rst_load_ready", {31'b0, load_ready}, 32'd0);
        check("rst_busy",       {31'b0, busy},       32'd0);
        check("rst_done",       {31'b0, done},       32'd0);
        check("rst_err",        {31'b0, err},        32'd0);
        check("rst_dump_valid", {31'b0, dump_valid}, 32'd0);
        check("rst_run_cycles", run_cycles,          32'd0);
        check("rst_acc_dataR",  acc_dataR,           32'd0);
        reset = 1'b0;

        // accelerator access while IDLE
        @(negedge clk);
        acc_en = 1'b1; acc_addr = 16'h0005;
        @(negedge clk);
        acc_en = 1'b0;
        check("err_idle_access", {31'b0, err}, 32'd1);
        check("idle_not_busy", {31'b0, busy}, 32'd0);

        pulse_go();
        check("err_clear_on_go", {31'b0, err}, 32'd0);
        check("load_ready_in_load", {31'b0, load_ready}, 32'd1);

        do_load(60, acc_cnt);
        check("load_count", 32'(acc_cnt), 32'(IMG_WORDS));
        check("load_ready_dropped", {31'b0, load_ready}, 32'd0);
        check("acc_start_pulse", {31'b0, acc_start}, 32'd1);

        // ---- RUN ----
        run_n = 0;
        run_cyc(1'b1, 1'b0, 16'h0005, 32'h0, 1'b0);
        check("acc_start_single", {31'b0, acc_start}, 32'd0);
        run_cyc(1'b0, 1'b0, 16'h0, 32'h0, 1'b0);
        check("rd_t1", acc_dataR, 32'h0000_0005);
        run_cyc(1'b0, 1'b0, 16'h0, 32'h0, 1'b0);
        check("rd_t2_hold", acc_dataR, 32'h0000_0005);
        run_cyc(1'b1, 1'b1, 16'h6300, 32'hDEADBEEF, 1'b0);
        run_cyc(1'b1, 1'b0, 16'h6300, 32'h0, 1'b0);
        check("wr_keeps_rdata", acc_dataR, 32'h0000_0005);
        run_cyc(1'b0, 1'b0, 16'h0, 32'h0, 1'b0);
        host_go = 1'b1;
        check("rd_after_wr", acc_dataR, 32'hDEADBEEF);
        run_cyc(1'b0, 1'b0, 16'h0, 32'h0, 1'b0);
        host_go = 1'b0;
        check("go_in_run_load_ready", {31'b0, load_ready}, 32'd0);
        check("go_in_run_busy", {31'b0, busy}, 32'd1);
        check("err_clean_run", {31'b0, err}, 32'd0);
        run_cyc(1'b1, 1'b1, 16'hC600, 32'h1234_5678, 1'b0);
        run_cyc(1'b0, 1'b0, 16'h0, 32'h0, 1'b0);
        check("err_oob_write", {31'b0, err}, 32'd1);
        run_cyc(1'b1, 1'b0, 16'hC600, 32'h0, 1'b0);
        run_cyc(1'b0, 1'b0, 16'h0, 32'h0, 1'b0);
        check("oob_read_zero", acc_dataR, 32'h0);
        run_cyc(1'b1, 1'b0, 16'h4600, 32'h0, 1'b0);
        run_cyc(1'b0, 1'b0, 16'h0, 32'h0, 1'b0);
        check("oob_no_alias", acc_dataR, 32'd17920);
        run_cyc(1'b1, 1'b0, 16'h62FF, 32'h0, 1'b0);
        run_cyc(1'b0, 1'b0, 16'h0, 32'h0, 1'b0);
        check("rd_last_load_word", acc_dataR, 32'd25343);
        run_cyc(1'b1, 1'b0, 16'd20, 32'h0, 1'b0);
        run_cyc(1'b0, 1'b0, 16'h0, 32'h0, 1'b0);
        check("rd_gap_loaded_word", acc_dataR, 32'd20);
        for (int i = 1; i < 8; i++)
            run_cyc(1'b1, 1'b1, 16'(OUT_BASE + i), 32'hA000_0000 | 32'(i), 1'b0);
        run_cyc(1'b1, 1'b1, 16'(OUT_BASE + IMG_WORDS - 2), 32'hB000_0001, 1'b0);
        run_cyc(1'b1, 1'b1, 16'(OUT_BASE + IMG_WORDS - 1), 32'hB000_0002, 1'b0);
        run_cyc(1'b1, 1'b0, 16'(OUT_BASE + 3), 32'h0, 1'b0);
        run_cyc(1'b0, 1'b0, 16'h0, 32'h0, 1'b0);
        check("rd_result_word", acc_dataR, 32'hA000_0003);
        while (run_n < 99) run_cyc(1'b0, 1'b0, 16'h0, 32'h0, 1'b0);
        run_cyc(1'b0, 1'b0, 16'h0, 32'h0, 1'b1);

        do_dump_full();

        // ---- second sequence from DONE ----
        @(negedge clk);
        acc_en = 1'b1; acc_addr = 16'h0;
        @(negedge clk);
        acc_en = 1'b0;
        check("err_done_access", {31'b0, err}, 32'd1);
        pulse_go();
        check("err_clear_on_go2", {31'b0, err}, 32'd0);
        check("run_cycles_clear", run_cycles, 32'd0);
        do_load(0, acc_cnt);
        check("load_count2", 32'(acc_cnt), 32'(IMG_WORDS));
        run_n = 0;
        run_cyc(1'b0, 1'b0, 16'h0, 32'h0, 1'b0);
        run_cyc(1'b0, 1'b0, 16'h0, 32'h0, 1'b0);
        run_cyc(1'b0, 1'b0, 16'h0, 32'h0, 1'b1);
        @(negedge clk);
        acc_finish = 1'b0;
        dump_ready = 1'b1;
        check("run_cycles_3", run_cycles, 32'd3);
        for (int i = 0; i < 10; i++) begin
            if (dump_valid) break;
            @(negedge clk);
        end
        check("dump2_valid", {31'b0, dump_valid}, 32'd1);
        check("dump2_word0_kept", dump_data, 32'hDEADBEEF);
        @(negedge clk);
        check("dump2_word1", dump_data, 32'hA000_0001);

        // reset in the middle of DUMP
        reset = 1'b1;
        #1;
        check("rstmid_dump_valid", {31'b0, dump_valid}, 32'd0);
        check("rstmid_dump_data",  dump_data,           32'd0);
        check("rstmid_dump_last",  {31'b0, dump_last},  32'd0);
        check("rstmid_busy",       {31'b0, busy},       32'd0);
        check("rstmid_done",       {31'b0, done},       32'd0);
        check("rstmid_acc_start",  {31'b0, acc_start},  32'd0);
        check("rstmid_load_ready", {31'b0, load_ready}, 32'd0);
        check("rstmid_run_cycles", run_cycles,          32'd0);
        check("rstmid_acc_dataR",  acc_dataR,           32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("idle_after_reset_busy", {31'b0, busy}, 32'd0);
        check("idle_after_reset_done", {31'b0, done}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
